// File: rtl/ula_operand_loader.sv
// ula_operand_loader: steps opcode, A and B off one switch bus into ula, then latches Saida after ULA_LAT cycles.
// Define ULA_LOADER_OPCNT_EN to add a saturating completed-operation counter on op_count.
module ula_operand_loader #(
  parameter int SEL_W   = 4,
  parameter int A_W     = 2,
  parameter int B_W     = 2,
  parameter int RES_W   = 3,
  parameter int ULA_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       din,
  input  logic             btn_next,
  input  logic             btn_clear,
  input  logic [RES_W-1:0] ula_saida,
  output logic [SEL_W-1:0] sel,
  output logic [A_W-1:0]   a,
  output logic [B_W-1:0]   b,
  output logic [RES_W-1:0] res,
  output logic             done,
  output logic             busy,
  output logic [2:0]       state_dbg,
  output logic [7:0]       op_count
);
  typedef enum logic [2:0] {S_SEL, S_A, S_B, S_EXEC, S_WAIT, S_SHOW} state_t;
  localparam logic [3:0] LAST = (ULA_LAT == 0) ? 4'd0 : 4'(ULA_LAT - 1);
  state_t     state;
  logic       btn_prev;
  logic [3:0] cnt;
  logic       step;
  assign step      = btn_next & ~btn_prev;
  assign busy      = (state == S_EXEC) || (state == S_WAIT);
  assign state_dbg = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_SEL;
      btn_prev <= 1'b0;
      cnt      <= '0;
      sel      <= '0;
      a        <= '0;
      b        <= '0;
      res      <= '0;
      done     <= 1'b0;
    end else begin
      btn_prev <= btn_next;
      done     <= 1'b0;
      case (state)
        S_SEL:   if (btn_clear) state <= S_SEL;
                 else if (step) begin sel <= din[SEL_W-1:0]; state <= S_A; end
        S_A:     if (btn_clear) state <= S_SEL;
                 else if (step) begin a <= din[A_W-1:0]; state <= S_B; end
        S_B:     if (btn_clear) state <= S_SEL;
                 else if (step) begin b <= din[B_W-1:0]; state <= S_EXEC; end
        S_EXEC:  begin cnt <= '0; state <= S_WAIT; end
        S_WAIT:  if (cnt == LAST) begin res <= ula_saida; done <= 1'b1; state <= S_SHOW; end
                 else cnt <= cnt + 4'd1;
        S_SHOW:  if (btn_clear || step) state <= S_SEL;
        default: state <= S_SEL;
      endcase
    end
  end
`ifdef ULA_LOADER_OPCNT_EN
  always_ff @(posedge clk) begin
    if (rst) op_count <= 8'd0;
    else if (done && op_count != 8'hff) op_count <= op_count + 8'd1;
  end
`else
  assign op_count = 8'd0;
`endif
endmodule

// File: tb/tb_ula_operand_loader.sv
// tb_ula_operand_loader: directed vectors against a toy combinational ula (sel 0 adds, others AND).
module tb_ula_operand_loader;
  logic       clk = 1'b0;
  logic       rst, btn_next, btn_clear;
  logic [3:0] din;
  logic [2:0] ula_saida, res, state_dbg;
  logic [3:0] sel;
  logic [1:0] a, b;
  logic       done, busy;
  logic [7:0] op_count;
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign ula_saida = (sel == 4'd0) ? ({1'b0, a} + {1'b0, b}) : {1'b0, a & b};

  ula_operand_loader dut (
    .clk(clk), .rst(rst), .din(din), .btn_next(btn_next), .btn_clear(btn_clear),
    .ula_saida(ula_saida), .sel(sel), .a(a), .b(b), .res(res), .done(done),
    .busy(busy), .state_dbg(state_dbg), .op_count(op_count)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input int d);
    din = 4'(d);
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    tick();
  endtask

  initial begin
    int s, av, bv;
    rst = 1'b1; din = '0; btn_next = 1'b0; btn_clear = 1'b0;
    tick(); tick();
    chk("rst_sel", sel, 0); chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_res", res, 0);
    chk("rst_done", done, 0); chk("rst_busy", busy, 0); chk("rst_state", state_dbg, 0);
    chk("rst_opcnt", op_count, 0);
    rst = 1'b0;
    tick();
    // basic sum 2+1
    press(0); press(2); press(1);
    chk("sum_busy", busy, 1); chk("sum_wait", state_dbg, 4); chk("sum_early", done, 0);
    tick();
    chk("sum_done", done, 1); chk("sum_res", res, 3); chk("sum_sel", sel, 0);
    chk("sum_a", a, 2); chk("sum_b", b, 1); chk("sum_show", state_dbg, 5); chk("sum_nbusy", busy, 0);
    tick();
    chk("sum_pulse", done, 0); chk("sum_hold", res, 3);
    press(0);
    chk("show_to_sel", state_dbg, 0);
    // held button steps once
    din = 4'b0101; btn_next = 1'b1;
    repeat (6) tick();
    chk("hold_sel", sel, 5); chk("hold_state", state_dbg, 1); chk("hold_a", a, 2);
    btn_next = 1'b0; tick();
    chk("rel_state", state_dbg, 1);
    press(1);
    chk("repress_a", a, 1); chk("repress_state", state_dbg, 2);
    // clear beats step in S_B
    din = 4'b0011; btn_next = 1'b1; btn_clear = 1'b1;
    tick();
    chk("clr_state", state_dbg, 0); chk("clr_b", b, 1); chk("clr_done", done, 0);
    btn_next = 1'b0; btn_clear = 1'b0; tick();
    chk("clr_idle", state_dbg, 0);
    // clear ignored while busy, honoured in S_SHOW
    press(0); press(3);
    din = 4'd1; btn_next = 1'b1; tick();
    chk("busy_exec", state_dbg, 3);
    btn_next = 1'b0; btn_clear = 1'b1; tick();
    chk("busy_clr_ign", state_dbg, 4);
    tick();
    chk("busy_done", done, 1); chk("busy_res", res, 4);
    tick();
    chk("show_clr", state_dbg, 0); chk("show_clr_res", res, 4); chk("show_clr_done", done, 0);
    btn_clear = 1'b0; tick();
    // reset mid-operation
    press(0); press(2); press(1);
    chk("mid_wait", state_dbg, 4);
    rst = 1'b1; tick();
    chk("mid_state", state_dbg, 0); chk("mid_busy", busy, 0); chk("mid_res", res, 0);
    chk("mid_done", done, 0); chk("mid_sel", sel, 0); chk("mid_b", b, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); chk("mid_nodone", done, 0); end
    // 260 operations, counter saturation
    for (int i = 0; i < 260; i++) begin
      s = i % 16; av = (i / 16) % 4; bv = (i / 64) % 4;
      press(s); press(av); press(bv);
      tick();
      chk("op_done", done, 1);
      chk("op_res", res, (s == 0) ? av + bv : (av & bv));
      if (i < 4) begin chk("op_sel", sel, s); chk("op_a", a, av); chk("op_b", b, bv); end
      press(0);
    end
    tick();
`ifdef ULA_LOADER_OPCNT_EN
    chk("opcnt_sat", op_count, 255);
`else
    chk("opcnt_off", op_count, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
